eoc_collector: RTL and testbench

EOC_COLLECTOR -- requirements
Module: eoc_collector

---
 rtl/eoc_collector.sv | 211 +++++++++++++++++++++
 tb/tb_eoc_collector.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eoc_collector.sv
// eoc_collector: gathers end-of-computation reports from NumChan channels.
// Each channel writes a word whose bit 0 is "done" and whose upper bits are
// an exit code. Once every channel has reported done, eoc_valid_o rises and
// eoc_code_o/eoc_chan_o hold the first nonzero exit code and its channel.
// An optional idle timeout and a sticky duplicate-done flag report misbehaving
// software. The boot-mode strap is captured once, on the first cycle after reset.
//
// Handshake: a write on channel i is accepted on a rising clk_i edge where
// wr_valid_i[i] and wr_ready_o[i] are both 1. wr_ready_o is all-ones only in
// RUN and does not depend on wr_valid_i. A write presented in a cycle that
// also has clear_i asserted is not accepted.
module eoc_collector #(
    parameter int NumChan       = 4,
    parameter int CodeWidth     = 32,
    parameter int TimeoutCycles = 0,
    localparam int ChanW        = (NumChan > 1) ? $clog2(NumChan) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [1:0]                   boot_mode_i,
    output logic [1:0]                   boot_mode_o,
    input  logic [NumChan-1:0]           wr_valid_i,
    input  logic [NumChan*CodeWidth-1:0] wr_data_i,
    output logic [NumChan-1:0]           wr_ready_o,
    input  logic                         clear_i,
    output logic [NumChan-1:0]           done_mask_o,
    output logic                         eoc_valid_o,
    output logic [CodeWidth-2:0]         eoc_code_o,
    output logic [ChanW-1:0]             eoc_chan_o,
    output logic                         timeout_o,
    output logic                         dup_err_o,
    output logic [1:0]                   state_o
);

    // FSM encoding; state_o exposes the current state for observation.
    localparam logic [1:0] LATCH = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] TMO   = 2'd3;

    localparam logic [31:0] TMO_LIMIT = 32'(TimeoutCycles);
    localparam bit          TMO_EN    = (TimeoutCycles != 0);

    logic [1:0]           state, state_next;
    logic [1:0]           boot_mode, boot_mode_next;
    logic [NumChan-1:0]   mask, mask_next;
    logic                 valid, valid_next;
    logic [CodeWidth-2:0] code, code_next;
    logic [ChanW-1:0]     chan, chan_next;
    logic                 timeout, timeout_next;
    logic                 dup, dup_next;
    logic [31:0]          idle_cnt, idle_cnt_next;
    logic [31:0]          idle_inc;

    logic                 run;
    logic                 any_accepted;
    logic                 any_dup;
    logic [NumChan-1:0]   accepted;
    logic [NumChan-1:0]   done_wr;
    logic [NumChan-1:0]   fresh_done;
    logic                 pick_hit;
    logic [CodeWidth-2:0] pick_code;
    logic [ChanW-1:0]     pick_chan;

    assign run = (state == RUN);

    // Per-channel accept and done decode; clear_i suppresses every write.
    always_comb begin
        accepted = '0;
        done_wr  = '0;
        for (int i = 0; i < NumChan; i++) begin
            accepted[i] = wr_valid_i[i] & run & ~clear_i;
            done_wr[i]  = accepted[i] & wr_data_i[i*CodeWidth];
        end
    end

    // Only the first done per channel counts; a repeat is flagged and dropped.
    assign fresh_done   = done_wr & ~mask;
    assign any_dup      = |(done_wr & mask);
    assign any_accepted = |accepted;

    // Lowest-index fresh done-write with a nonzero code: scanning downward
    // lets the lowest index overwrite any higher one.
    always_comb begin
        pick_hit  = 1'b0;
        pick_code = '0;
        pick_chan = '0;
        for (int i = NumChan - 1; i >= 0; i--) begin
            if (fresh_done[i] && (wr_data_i[i*CodeWidth+1 +: CodeWidth-1] != '0)) begin
                pick_hit  = 1'b1;
                pick_code = wr_data_i[i*CodeWidth+1 +: CodeWidth-1];
                pick_chan = ChanW'(i);
            end
        end
    end

    // Saturating idle increment.
    assign idle_inc = (&idle_cnt) ? idle_cnt : idle_cnt + 32'd1;

    // Next-state and datapath update. A captured code is nonzero by
    // construction, so code != 0 doubles as the "already captured" flag.
    always_comb begin
        state_next     = state;
        boot_mode_next = boot_mode;
        mask_next      = mask;
        valid_next     = valid;
        code_next      = code;
        chan_next      = chan;
        timeout_next   = timeout;
        dup_next       = dup;
        idle_cnt_next  = idle_cnt;

        case (state)
            LATCH: begin
                boot_mode_next = boot_mode_i;
                state_next     = RUN;
            end

            RUN: begin
                if (clear_i) begin
                    mask_next     = '0;
                    valid_next    = 1'b0;
                    code_next     = '0;
                    chan_next     = '0;
                    timeout_next  = 1'b0;
                    dup_next      = 1'b0;
                    idle_cnt_next = '0;
                end else begin
                    mask_next     = mask | fresh_done;
                    idle_cnt_next = any_accepted ? 32'd0 : idle_inc;
                    if (any_dup) begin
                        dup_next = 1'b1;
                    end
                    if (pick_hit && (code == '0)) begin
                        code_next = pick_code;
                        chan_next = pick_chan;
                    end
                    // Completion takes priority over a coincident timeout.
                    if (&mask_next) begin
                        state_next = DONE;
                        valid_next = 1'b1;
                    end else if (TMO_EN && (idle_cnt_next >= TMO_LIMIT)) begin
                        state_next   = TMO;
                        timeout_next = 1'b1;
                    end
                end
            end

            DONE, TMO: begin
                if (clear_i) begin
                    state_next    = RUN;
                    mask_next     = '0;
                    valid_next    = 1'b0;
                    code_next     = '0;
                    chan_next     = '0;
                    timeout_next  = 1'b0;
                    dup_next      = 1'b0;
                    idle_cnt_next = '0;
                end
            end

            default: begin
                state_next = LATCH;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= LATCH;
            boot_mode <= '0;
            mask      <= '0;
            valid     <= 1'b0;
            code      <= '0;
            chan      <= '0;
            timeout   <= 1'b0;
            dup       <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            state     <= state_next;
            boot_mode <= boot_mode_next;
            mask      <= mask_next;
            valid     <= valid_next;
            code      <= code_next;
            chan      <= chan_next;
            timeout   <= timeout_next;
            dup       <= dup_next;
            idle_cnt  <= idle_cnt_next;
        end
    end

    assign boot_mode_o = boot_mode;
    assign wr_ready_o  = {NumChan{run}};
    assign done_mask_o = mask;
    assign eoc_valid_o = valid;
    assign eoc_code_o  = code;
    assign timeout_o   = timeout;
    assign dup_err_o   = dup;
    assign state_o     = state;

    // A single channel can only ever be channel 0.
    generate
        if (NumChan == 1) begin : g_one_chan
            assign eoc_chan_o = '0;
        end else begin : g_multi_chan
            assign eoc_chan_o = chan;
        end
    endgenerate

endmodule

// File: tb/tb_eoc_collector.sv
// Directed testbench for eoc_collector: four channels, 8-bit write words,
// idle timeout of 100 cycles. Inputs change 1 ns after a rising edge and
// outputs are compared at that same point, after the edge has settled.
module tb_eoc_collector;

    localparam int NC = 4;
    localparam int CW = 8;
    localparam int TO = 100;

    localparam logic [1:0] S_LATCH = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_TMO   = 2'd3;

    logic            clk;
    logic            rst;
    logic [1:0]      boot_mode_i;
    logic [1:0]      boot_mode_o;
    logic [NC-1:0]   wr_valid;
    logic [NC*CW-1:0] wr_data;
    logic [NC-1:0]   wr_ready;
    logic            clear;
    logic [NC-1:0]   done_mask;
    logic            eoc_valid;
    logic [CW-2:0]   eoc_code;
    logic [1:0]      eoc_chan;
    logic            timeout;
    logic            dup_err;
    logic [1:0]      state;

    int checks   = 0;
    int failures = 0;

    eoc_collector #(
        .NumChan       (NC),
        .CodeWidth     (CW),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .boot_mode_i (boot_mode_i),
        .boot_mode_o (boot_mode_o),
        .wr_valid_i  (wr_valid),
        .wr_data_i   (wr_data),
        .wr_ready_o  (wr_ready),
        .clear_i     (clear),
        .done_mask_o (done_mask),
        .eoc_valid_o (eoc_valid),
        .eoc_code_o  (eoc_code),
        .eoc_chan_o  (eoc_chan),
        .timeout_o   (timeout),
        .dup_err_o   (dup_err),
        .state_o     (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid = '0;
        wr_data  = '0;
        clear    = 1'b0;
    endtask

    task automatic put(input int ch, input logic done, input logic [CW-2:0] c);
        wr_valid[ch]         = 1'b1;
        wr_data[ch*CW +: CW] = {c, done};
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        idle_inputs();
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1;
        boot_mode_i = 2'd2;
        idle_inputs();
        step();
        step();
        checks++;
        if ({boot_mode_o, wr_ready, done_mask, eoc_valid, eoc_code, eoc_chan, timeout, dup_err} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", {boot_mode_o, wr_ready, done_mask, eoc_valid, eoc_code, eoc_chan, timeout, dup_err});
        end
        checks++;
        if (state !== S_LATCH) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, S_LATCH); end
        rst = 1'b0;
        checks++;
        if (state !== S_LATCH) begin failures++; $display("FAIL release_state got=%0d exp=%0d", state, S_LATCH); end
        step();
        checks++;
        if (state !== S_RUN) begin failures++; $display("FAIL latch_to_run got=%0d exp=%0d", state, S_RUN); end
        checks++;
        if (boot_mode_o !== 2'd2) begin failures++; $display("FAIL boot_latch got=%0d exp=2", boot_mode_o); end
        checks++;
        if (wr_ready !== 4'hf) begin failures++; $display("FAIL ready_run got=%0h exp=f", wr_ready); end
        boot_mode_i = 2'd0;
        repeat (3) step();
        checks++;
        if (boot_mode_o !== 2'd2) begin failures++; $display("FAIL boot_hold got=%0d exp=2", boot_mode_o); end
        do_clear();
        checks++;
        if (boot_mode_o !== 2'd2) begin failures++; $display("FAIL boot_clear got=%0d exp=2", boot_mode_o); end
    endtask

    task automatic test_all_zero();
        logic [NC-1:0] exp_mask;
        do_clear();
        put(0, 1'b0, 7'd5);
        step();
        idle_inputs();
        checks++;
        if (done_mask !== 4'h0) begin failures++; $display("FAIL heartbeat_mask got=%0h exp=0", done_mask); end
        exp_mask = '0;
        for (int ch = 0; ch < NC; ch++) begin
            put(ch, 1'b1, 7'd0);
            step();
            idle_inputs();
            exp_mask[ch] = 1'b1;
            checks++;
            if (done_mask !== exp_mask) begin failures++; $display("FAIL zero_mask ch=%0d got=%0h exp=%0h", ch, done_mask, exp_mask); end
            checks++;
            if (eoc_valid !== (ch == NC - 1)) begin failures++; $display("FAIL zero_valid ch=%0d got=%0b exp=%0b", ch, eoc_valid, (ch == NC - 1)); end
        end
        checks++;
        if ({eoc_code, eoc_chan} !== 9'd0) begin failures++; $display("FAIL zero_code got=%0h/%0d exp=0/0", eoc_code, eoc_chan); end
        checks++;
        if (state !== S_DONE) begin failures++; $display("FAIL zero_state got=%0d exp=%0d", state, S_DONE); end
        checks++;
        if (wr_ready !== 4'h0) begin failures++; $display("FAIL ready_done got=%0h exp=0", wr_ready); end
        put(0, 1'b1, 7'd3);
        step();
        idle_inputs();
        checks++;
        if ({eoc_code, dup_err} !== 8'd0) begin failures++; $display("FAIL done_ignores got=%0h/%0b exp=0/0", eoc_code, dup_err); end
    endtask

    task automatic test_same_cycle();
        do_clear();
        checks++;
        if ({state, eoc_valid} !== {S_RUN, 1'b0}) begin failures++; $display("FAIL clear_from_done got=%0d/%0b exp=%0d/0", state, eoc_valid, S_RUN); end
        put(1, 1'b1, 7'd5);
        put(2, 1'b1, 7'd9);
        step();
        idle_inputs();
        checks++;
        if ({eoc_code, eoc_chan} !== {7'd5, 2'd1}) begin failures++; $display("FAIL same_cycle_pick got=%0d/%0d exp=5/1", eoc_code, eoc_chan); end
        checks++;
        if (done_mask !== 4'b0110) begin failures++; $display("FAIL same_cycle_mask got=%0h exp=6", done_mask); end
        put(0, 1'b1, 7'd0);
        put(3, 1'b1, 7'd0);
        step();
        idle_inputs();
        checks++;
        if ({eoc_valid, eoc_code, eoc_chan} !== {1'b1, 7'd5, 2'd1}) begin failures++; $display("FAIL same_cycle_final got=%0b/%0d/%0d exp=1/5/1", eoc_valid, eoc_code, eoc_chan); end
    endtask

    task automatic test_first_wins();
        do_clear();
        put(3, 1'b1, 7'd7);
        step();
        idle_inputs();
        checks++;
        if ({eoc_code, eoc_chan} !== {7'd7, 2'd3}) begin failures++; $display("FAIL first_pick got=%0d/%0d exp=7/3", eoc_code, eoc_chan); end
        put(0, 1'b1, 7'd2);
        step();
        idle_inputs();
        checks++;
        if ({eoc_code, eoc_chan, done_mask} !== {7'd7, 2'd3, 4'b1001}) begin failures++; $display("FAIL first_keep got=%0d/%0d/%0h exp=7/3/9", eoc_code, eoc_chan, done_mask); end
        put(1, 1'b1, 7'd0);
        put(2, 1'b1, 7'd0);
        step();
        idle_inputs();
        checks++;
        if ({state, eoc_valid} !== {S_DONE, 1'b1}) begin failures++; $display("FAIL first_done got=%0d/%0b exp=%0d/1", state, eoc_valid, S_DONE); end
    endtask

    task automatic test_dup();
        do_clear();
        put(2, 1'b1, 7'd0);
        step();
        idle_inputs();
        checks++;
        if ({dup_err, done_mask} !== {1'b0, 4'b0100}) begin failures++; $display("FAIL dup_first got=%0b/%0h exp=0/4", dup_err, done_mask); end
        put(2, 1'b1, 7'd3);
        step();
        idle_inputs();
        checks++;
        if (dup_err !== 1'b1) begin failures++; $display("FAIL dup_set got=%0b exp=1", dup_err); end
        checks++;
        if ({done_mask, eoc_code} !== {4'b0100, 7'd0}) begin failures++; $display("FAIL dup_ignored got=%0h/%0d exp=4/0", done_mask, eoc_code); end
        do_clear();
        checks++;
        if ({dup_err, done_mask, state} !== {1'b0, 4'b0000, S_RUN}) begin failures++; $display("FAIL dup_clear got=%0b/%0h/%0d exp=0/0/%0d", dup_err, done_mask, state, S_RUN); end
    endtask

    task automatic test_clear_writes();
        clear = 1'b1;
        put(0, 1'b1, 7'd4);
        put(1, 1'b1, 7'd0);
        step();
        idle_inputs();
        checks++;
        if ({done_mask, eoc_code} !== 11'd0) begin failures++; $display("FAIL clear_writes got=%0h/%0d exp=0/0", done_mask, eoc_code); end
    endtask

    task automatic test_timeout();
        do_clear();
        repeat (49) step();
        put(0, 1'b0, 7'd0);
        step();
        idle_inputs();
        repeat (TO - 1) step();
        checks++;
        if ({timeout, state} !== {1'b0, S_RUN}) begin failures++; $display("FAIL timeout_early got=%0b/%0d exp=0/%0d", timeout, state, S_RUN); end
        step();
        checks++;
        if ({timeout, state} !== {1'b1, S_TMO}) begin failures++; $display("FAIL timeout_fire got=%0b/%0d exp=1/%0d", timeout, state, S_TMO); end
        checks++;
        if (wr_ready !== 4'h0) begin failures++; $display("FAIL ready_tmo got=%0h exp=0", wr_ready); end
        put(0, 1'b1, 7'd1);
        step();
        idle_inputs();
        checks++;
        if (done_mask !== 4'h0) begin failures++; $display("FAIL tmo_ignores got=%0h exp=0", done_mask); end
        do_clear();
        checks++;
        if ({timeout, state, wr_ready} !== {1'b0, S_RUN, 4'hf}) begin failures++; $display("FAIL tmo_clear got=%0b/%0d/%0h exp=0/%0d/f", timeout, state, wr_ready, S_RUN); end
    endtask

    task automatic test_write_wins();
        do_clear();
        put(0, 1'b1, 7'd0);
        put(1, 1'b1, 7'd0);
        put(2, 1'b1, 7'd0);
        step();
        idle_inputs();
        repeat (TO - 1) step();
        put(3, 1'b1, 7'd0);
        step();
        idle_inputs();
        checks++;
        if ({state, timeout, eoc_valid} !== {S_DONE, 1'b0, 1'b1}) begin failures++; $display("FAIL write_wins got=%0d/%0b/%0b exp=%0d/0/1", state, timeout, eoc_valid, S_DONE); end
    endtask

    task automatic test_reset_mid();
        do_clear();
        put(0, 1'b1, 7'd6);
        put(1, 1'b1, 7'd0);
        put(2, 1'b1, 7'd0);
        step();
        idle_inputs();
        checks++;
        if (done_mask !== 4'b0111) begin failures++; $display("FAIL mid_mask got=%0h exp=7", done_mask); end
        boot_mode_i = 2'd1;
        rst = 1'b1;
        #1;
        checks++;
        if ({boot_mode_o, wr_ready, done_mask, eoc_valid, eoc_code, eoc_chan, timeout, dup_err} !== 22'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%0h exp=0", {boot_mode_o, wr_ready, done_mask, eoc_valid, eoc_code, eoc_chan, timeout, dup_err});
        end
        checks++;
        if (state !== S_LATCH) begin failures++; $display("FAIL mid_reset_state got=%0d exp=%0d", state, S_LATCH); end
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({state, boot_mode_o} !== {S_RUN, 2'd1}) begin failures++; $display("FAIL mid_rerun got=%0d/%0d exp=%0d/1", state, boot_mode_o, S_RUN); end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_all_zero();
        test_same_cycle();
        test_first_wins();
        test_dup();
        test_clear_writes();
        test_timeout();
        test_write_wins();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time limit
    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "time limit reached");
    end

endmodule
